// File: rtl/csa9_accum.sv
// csa9_accum: accumulates NSAMP unsigned 9-bit samples into a 9-bit sum
// built from a 3-block carry-select adder, then holds the result behind a
// valid/ready handshake until it is consumed.
//
// Parameters:
//   NSAMP      samples summed per result (1..255)
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   clr        synchronous clear of all accumulation state (highest priority)
//   in_valid   in_data carries a valid sample
//   in_ready   block accepts a sample this cycle (state ACC)
//   in_data    9-bit unsigned sample
//   out_valid  out_sum/out_ovf hold a completed result (state DONE)
//   out_ready  downstream consumes the result this cycle
//   out_sum    accumulated 9-bit sum
//   out_ovf    sticky carry-out flag for the current result
// Build option:
//   CSA9_ACCUM_SAT_EN  when defined, a carry-out saturates the sum to 9'h1FF;
//                      otherwise the sum wraps modulo 512.
module csa9_accum #(
  parameter int unsigned NSAMP = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [8:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [8:0] out_sum,
  output logic       out_ovf
);

  typedef enum logic {ST_ACC, ST_DONE} state_e;

  localparam logic [7:0] CNT_LAST = 8'(NSAMP - 1);

  state_e     state_q, state_d;
  logic [8:0] acc_q, acc_d;
  logic       ovf_q, ovf_d;
  logic [7:0] cnt_q, cnt_d;

  logic       xfer;
  logic       last;

  // Carry-select adder, 3-bit blocks. Block 0 has carry-in 0; blocks 1 and 2
  // precompute both carry-in cases and the incoming carry picks one.
  logic [3:0] blk0;
  logic [3:0] blk1_c0, blk1_c1;
  logic [3:0] blk2_c0, blk2_c1;
  logic       c3, c6;
  logic [8:0] add_sum;
  logic       add_co;

  assign blk0    = {1'b0, acc_q[2:0]} + {1'b0, in_data[2:0]};
  assign blk1_c0 = {1'b0, acc_q[5:3]} + {1'b0, in_data[5:3]};
  assign blk1_c1 = {1'b0, acc_q[5:3]} + {1'b0, in_data[5:3]} + 4'd1;
  assign blk2_c0 = {1'b0, acc_q[8:6]} + {1'b0, in_data[8:6]};
  assign blk2_c1 = {1'b0, acc_q[8:6]} + {1'b0, in_data[8:6]} + 4'd1;

  assign c3           = blk0[3];
  assign add_sum[2:0] = blk0[2:0];
  assign add_sum[5:3] = c3 ? blk1_c1[2:0] : blk1_c0[2:0];
  assign c6           = c3 ? blk1_c1[3]   : blk1_c0[3];
  assign add_sum[8:6] = c6 ? blk2_c1[2:0] : blk2_c0[2:0];
  assign add_co       = c6 ? blk2_c1[3]   : blk2_c0[3];

  assign xfer = in_valid && in_ready;
  assign last = (cnt_q == CNT_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACC;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = ST_ACC;
    end else begin
      unique case (state_q)
        ST_ACC:  if (xfer && last) state_d = ST_DONE;
        ST_DONE: if (out_ready)    state_d = ST_ACC;
        default: state_d = ST_ACC;
      endcase
    end
  end

  // Output logic
  always_comb begin
    in_ready  = (state_q == ST_ACC);
    out_valid = (state_q == ST_DONE);
    out_sum   = acc_q;
    out_ovf   = ovf_q;
  end

  // Accumulator next-state
  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    cnt_d = cnt_q;
    if (clr) begin
      acc_d = '0;
      ovf_d = 1'b0;
      cnt_d = '0;
    end else if (state_q == ST_DONE) begin
      if (out_ready) begin
        acc_d = '0;
        ovf_d = 1'b0;
        cnt_d = '0;
      end
    end else if (xfer) begin
`ifdef CSA9_ACCUM_SAT_EN
      // 9'h1FF plus any nonzero sample carries out, so saturation sticks.
      acc_d = add_co ? '1 : add_sum;
`else
      acc_d = add_sum;
`endif
      ovf_d = ovf_q | add_co;
      cnt_d = last ? '0 : cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
    end
  end

endmodule
